// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared register-index width and controller state encodings
package hazard_ctrl_pkg;
  localparam int RS_WIDTH = 5;
  typedef enum logic [1:0] {
    HC_ST_RUN     = 2'd0,
    HC_ST_MD_BUSY = 2'd1,
    HC_ST_MD_DONE = 2'd2
  } hc_state_e;
endpackage

// File: rtl/hazard_ctrl_muldiv_timer.sv
// muldiv_timer: fixed-latency mul/div countdown, zero flags completion
module muldiv_timer #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam int unsigned W = LATENCY > 1 ? $clog2(LATENCY) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign zero = cnt_q == '0;
  always_comb cnt_d = load ? W'(LATENCY - 1) : (en && !zero) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for load-use, branch, mul/div and dmem waits
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 0,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RS_WIDTH-1:0]  rs1_id,
  input  logic [RS_WIDTH-1:0]  rs2_id,
  input  logic                 use_rs1_id,
  input  logic                 use_rs2_id,
  input  logic [RS_WIDTH-1:0]  rd_ex,
  input  logic                 memread_ex,
  input  logic                 branch_taken_ex,
  input  logic                 muldiv_ex,
  input  logic                 muldiv_done,
  input  logic                 dmem_req_mem,
  input  logic                 dmem_ready,
  output logic                 muldiv_go,
  output logic                 muldiv_ack,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_mem,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 flush_mem,
  output logic                 flush_wb,
  output logic [CNT_WIDTH-1:0] stall_cycles
);
  hc_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic memwait, loaduse, md_zero, md_complete;
  assign memwait = dmem_req_mem && !dmem_ready;
  assign loaduse = memread_ex && rd_ex != '0 &&
                   ((use_rs1_id && rd_ex == rs1_id) || (use_rs2_id && rd_ex == rs2_id));
  generate
    if (MD_LATENCY > 0) begin : g_timer
      muldiv_timer #(.LATENCY(MD_LATENCY)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (muldiv_go),
        .en   (state_q == HC_ST_MD_BUSY),
        .zero (md_zero)
      );
    end else begin : g_no_timer
      assign md_zero = 1'b0;
    end
  endgenerate
  assign md_complete = (MD_LATENCY == 0) ? muldiv_done : md_zero;
  always_comb begin
    state_d    = state_q;
    muldiv_go  = 1'b0;
    muldiv_ack = 1'b0;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    flush_mem  = 1'b0;
    flush_wb   = 1'b0;
    if (!rst) begin
      {flush_id, flush_ex, flush_mem, flush_wb} = 4'hf;
    end else if (memwait) begin
      // a pending branch redirect waits here: EX is held, so it resurfaces afterwards
      {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = 5'h1f;
      if (state_q == HC_ST_MD_BUSY && md_complete) state_d = HC_ST_MD_DONE;
    end else if (state_q == HC_ST_RUN) begin
      if (muldiv_ex) begin
        {muldiv_go, stall_if, stall_id, stall_ex, flush_mem} = 5'h1f;
        state_d = HC_ST_MD_BUSY;
      end else if (branch_taken_ex) begin
        {flush_id, flush_ex} = 2'b11;
      end else if (loaduse) begin
        {stall_if, stall_id, flush_ex} = 3'b111;
      end
    end else if (state_q == HC_ST_MD_DONE || md_complete) begin
      muldiv_ack = 1'b1;
      state_d    = HC_ST_RUN;
    end else begin
      {stall_if, stall_id, stall_ex, flush_mem} = 4'hf;
    end
  end
  always_comb stall_cycles_d = (stall_if && !(&stall_cycles_q)) ? stall_cycles_q + CNT_WIDTH'(1) : stall_cycles_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= HC_ST_RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three controller instances (handshake, latency 4, 4-bit counter) against a behavioural model
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic [RS_WIDTH-1:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic use_rs1_id = 0, use_rs2_id = 0, memread_ex = 0, branch_taken_ex = 0, muldiv_ex = 0;
  logic muldiv_done = 0, dmem_req_mem = 0, dmem_ready = 0;
  logic go[3], ack[3], s_if[3], s_id[3], s_ex[3], s_mem[3], f_id[3], f_ex[3], f_mem[3], f_wb[3];
  logic [31:0] sc0, sc1;
  logic [3:0]  sc2;
  int errors = 0, checks = 0;
  // output vector order: go ack stall_if stall_id stall_ex stall_mem flush_id flush_ex flush_mem flush_wb
  localparam logic [9:0] V_RST  = 10'b00_0000_1111;
  localparam logic [9:0] V_LU   = 10'b00_1100_0100;
  localparam logic [9:0] V_BR   = 10'b00_0000_1100;
  localparam logic [9:0] V_GO   = 10'b10_1110_0010;
  localparam logic [9:0] V_BUSY = 10'b00_1110_0010;
  localparam logic [9:0] V_ACK  = 10'b01_0000_0000;
  localparam logic [9:0] V_MW   = 10'b00_1111_0001;
  int     lat[3]  = '{0, 4, 0};
  longint smax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
  bit     in_md[3], fin[3];
  int     k[3];
  longint msc[3];
  logic [9:0] e[3];

  always #5 clk = ~clk;

  `define HC_DUT(NAME, LAT, CW, I, SC) \
    hazard_ctrl #(.MD_LATENCY(LAT), .CNT_WIDTH(CW)) NAME ( \
      .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), \
      .use_rs2_id(use_rs2_id), .rd_ex(rd_ex), .memread_ex(memread_ex), \
      .branch_taken_ex(branch_taken_ex), .muldiv_ex(muldiv_ex), .muldiv_done(muldiv_done), \
      .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready), .muldiv_go(go[I]), .muldiv_ack(ack[I]), \
      .stall_if(s_if[I]), .stall_id(s_id[I]), .stall_ex(s_ex[I]), .stall_mem(s_mem[I]), \
      .flush_id(f_id[I]), .flush_ex(f_ex[I]), .flush_mem(f_mem[I]), .flush_wb(f_wb[I]), \
      .stall_cycles(SC));
  `HC_DUT(dut_hs, 0, 32, 0, sc0)
  `HC_DUT(dut_lat, 4, 32, 1, sc1)
  `HC_DUT(dut_sat, 0, 4, 2, sc2)

  function automatic logic [9:0] obs(int i);
    return {go[i], ack[i], s_if[i], s_id[i], s_ex[i], s_mem[i], f_id[i], f_ex[i], f_mem[i], f_wb[i]};
  endfunction
  function automatic longint obs_sc(int i);
    return i == 0 ? longint'(sc0) : i == 1 ? longint'(sc1) : longint'(sc2);
  endfunction

  // model: a mul/div is "in flight" from the go edge; it is finished once k busy cycles reach the latency
  // (or the unit reports done); the ack waits for the data memory to stop stalling
  function automatic bit md_finished(int i);
    return lat[i] == 0 ? (fin[i] || muldiv_done) : (k[i] >= lat[i]);
  endfunction
  function automatic logic [9:0] expect_of(int i);
    bit mw = dmem_req_mem && !dmem_ready;
    bit lu = memread_ex && rd_ex != 0 &&
             ((use_rs1_id && rd_ex == rs1_id) || (use_rs2_id && rd_ex == rs2_id));
    if (!rst) return V_RST;
    if (mw) return V_MW;
    if (in_md[i]) return md_finished(i) ? V_ACK : V_BUSY;
    if (muldiv_ex) return V_GO;
    if (branch_taken_ex) return V_BR;
    if (lu) return V_LU;
    return 10'b0;
  endfunction
  task automatic settle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) e[i] = expect_of(i);
  endtask
  task automatic adv();
    bit mw;
    @(posedge clk);
    mw = dmem_req_mem && !dmem_ready;
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        in_md[i] = 0; fin[i] = 0; k[i] = 0; msc[i] = 0;
      end else begin
        if (e[i][7] && msc[i] < smax[i]) msc[i]++;
        if (in_md[i]) begin
          if (md_finished(i)) begin
            if (mw) fin[i] = 1;
            else begin in_md[i] = 0; fin[i] = 0; end
          end
          k[i]++;
        end else if (e[i][9]) begin
          in_md[i] = 1; fin[i] = 0; k[i] = 1;
        end
      end
    end
    #1;
  endtask
  task automatic clear_inputs();
    {use_rs1_id, use_rs2_id, memread_ex, branch_taken_ex, muldiv_ex, muldiv_done, dmem_req_mem, dmem_ready} = '0;
    rs1_id = '0; rs2_id = '0; rd_ex = '0;
  endtask
  task automatic do_reset();
    clear_inputs();
    rst = 0; settle(); adv(); rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    settle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs(i) !== V_RST) begin errors++; $display("FAIL reset_outputs inst%0d: got %b expected %b", i, obs(i), V_RST); end
    end
    adv(); adv();
    settle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_sc(i) !== 0) begin errors++; $display("FAIL reset_counter inst%0d: got %0d expected 0", i, obs_sc(i)); end
    end
    adv();
    rst = 1;
  endtask

  task automatic test_loaduse();
    logic [9:0] want[5] = '{V_LU, 10'b0, 10'b0, V_LU, 10'b0};
    for (int t = 0; t < 5; t++) begin
      clear_inputs();
      case (t)
        0: begin memread_ex = 1; rd_ex = 5; rs2_id = 5; use_rs2_id = 1; end
        1: begin rs2_id = 5; use_rs2_id = 1; end
        2: begin memread_ex = 1; rd_ex = 0; rs2_id = 0; use_rs2_id = 1; end
        3: begin memread_ex = 1; rd_ex = 7; rs1_id = 7; use_rs1_id = 1; end
        default: begin memread_ex = 1; rd_ex = 7; rs1_id = 7; end
      endcase
      settle();
      checks++;
      if (obs(0) !== want[t]) begin errors++; $display("FAIL loaduse_step%0d: got %b expected %b", t, obs(0), want[t]); end
      adv();
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    memread_ex = 1; rd_ex = 5; rs2_id = 5; use_rs2_id = 1; branch_taken_ex = 1;
    settle();
    checks++;
    if (obs(0) !== V_BR) begin errors++; $display("FAIL branch_over_loaduse: got %b expected %b", obs(0), V_BR); end
    adv();
    dmem_req_mem = 1;
    settle();
    checks++;
    if (obs(0) !== V_MW) begin errors++; $display("FAIL branch_under_memwait: got %b expected %b", obs(0), V_MW); end
    adv();
    clear_inputs();
  endtask

  task automatic test_latency();
    longint s0;
    do_reset();
    s0 = sc1;
    muldiv_ex = 1;
    settle();
    checks++;
    if (obs(1) !== V_GO) begin errors++; $display("FAIL lat_go: got %b expected %b", obs(1), V_GO); end
    adv();
    for (int t = 1; t < 4; t++) begin
      settle();
      checks++;
      if (obs(1) !== V_BUSY) begin errors++; $display("FAIL lat_busy_T+%0d: got %b expected %b", t, obs(1), V_BUSY); end
      adv();
    end
    settle();
    checks++;
    if (obs(1) !== V_ACK) begin errors++; $display("FAIL lat_ack_T+4: got %b expected %b", obs(1), V_ACK); end
    adv();
    checks++;
    if (sc1 - s0 !== 4) begin errors++; $display("FAIL lat_stall_count: got %0d expected 4", sc1 - s0); end
  endtask

  task automatic test_back_to_back();
    settle();
    checks++;
    if (obs(1) !== V_GO) begin errors++; $display("FAIL back_to_back_go: got %b expected %b", obs(1), V_GO); end
    adv();
    muldiv_ex = 0;
  endtask

  task automatic test_handshake();
    settle();
    checks++;
    if (obs(0) !== V_BUSY) begin errors++; $display("FAIL hs_busy: got %b expected %b", obs(0), V_BUSY); end
    adv();
    dmem_req_mem = 1; dmem_ready = 0; muldiv_done = 1;
    for (int t = 0; t < 3; t++) begin
      settle();
      checks++;
      if (obs(0) !== V_MW) begin errors++; $display("FAIL hs_memwait%0d: got %b expected %b", t, obs(0), V_MW); end
      adv();
    end
    dmem_ready = 1;
    settle();
    checks++;
    if (obs(0) !== V_ACK) begin errors++; $display("FAIL hs_ack: got %b expected %b", obs(0), V_ACK); end
    adv();
    clear_inputs();
    settle();
    checks++;
    if (obs(0) !== 10'b0) begin errors++; $display("FAIL hs_after_ack: got %b expected %b", obs(0), 10'b0); end
    adv();
  endtask

  task automatic test_reset_busy();
    do_reset();
    muldiv_ex = 1;
    settle(); adv();
    muldiv_ex = 0;
    settle();
    checks++;
    if (obs(0) !== V_BUSY) begin errors++; $display("FAIL rb_busy: got %b expected %b", obs(0), V_BUSY); end
    adv();
    rst = 0;
    settle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs(i) !== V_RST) begin errors++; $display("FAIL rb_in_reset inst%0d: got %b expected %b", i, obs(i), V_RST); end
    end
    adv();
    rst = 1; muldiv_done = 1;
    settle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs(i) !== 10'b0 || obs_sc(i) !== 0) begin
        errors++; $display("FAIL rb_after_reset inst%0d: got %b/%0d expected %b/0", i, obs(i), obs_sc(i), 10'b0);
      end
    end
    adv();
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    muldiv_ex = 1;
    for (int t = 0; t < 20; t++) begin settle(); adv(); end
    checks++;
    if (sc2 !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", sc2); end
    checks++;
    if (sc0 !== 32'd20) begin errors++; $display("FAIL sat_wide: got %0d expected 20", sc0); end
    checks++;
    if (sc1 !== 32'd16) begin errors++; $display("FAIL sat_lat: got %0d expected 16", sc1); end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(99) >= 2;
      rs1_id = RS_WIDTH'($urandom_range(3));
      rs2_id = RS_WIDTH'($urandom_range(3));
      rd_ex = RS_WIDTH'($urandom_range(3));
      use_rs1_id = $urandom_range(1);
      use_rs2_id = $urandom_range(1);
      memread_ex = $urandom_range(99) < 40;
      branch_taken_ex = $urandom_range(99) < 15;
      muldiv_ex = $urandom_range(99) < 20;
      muldiv_done = $urandom_range(99) < 30;
      dmem_req_mem = $urandom_range(99) < 40;
      dmem_ready = $urandom_range(1);
      settle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== e[i]) begin errors++; $display("FAIL rand_out n%0d inst%0d: got %b expected %b", n, i, obs(i), e[i]); end
        checks++;
        if (obs_sc(i) !== msc[i]) begin errors++; $display("FAIL rand_cnt n%0d inst%0d: got %0d expected %0d", n, i, obs_sc(i), msc[i]); end
      end
      adv();
    end
    rst = 1;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_branch();
    test_latency();
    test_back_to_back();
    test_handshake();
    test_reset_busy();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
